// File: rtl/reg_file_sb_if.sv
// Register-file bus: decode-side read/issue signals, writeback signals and
// scoreboard/debug outputs.
interface reg_file_sb_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
);
  logic [ADDR_W-1:0]          RA;
  logic [ADDR_W-1:0]          RB;
  logic [DATA_W-1:0]          BusA;
  logic [DATA_W-1:0]          BusB;
  logic [ADDR_W-1:0]          RW;
  logic [DATA_W-1:0]          BusW;
  logic                       RegWr;
  logic                       IssueVal;
  logic [ADDR_W-1:0]          IssueRd;
  logic                       HazA;
  logic                       HazB;
  logic [NUM_REGS-1:0]        BusyVec;
  logic [DATA_W*NUM_REGS-1:0] DbgRegs;

  modport master (
    output RA, RB, RW, BusW, RegWr, IssueVal, IssueRd,
    input  BusA, BusB, HazA, HazB, BusyVec, DbgRegs
  );

  modport slave (
    input  RA, RB, RW, BusW, RegWr, IssueVal, IssueRd,
    output BusA, BusB, HazA, HazB, BusyVec, DbgRegs
  );
endinterface

// File: rtl/reg_file_sb.sv
// Parametrised register file with write-to-read bypass, optional zero register
// and per-register busy scoreboard. Define REGFILE_DBG_EN to expose DbgRegs.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1
) (
  input logic          Clk,
  input logic          Rst,
  reg_file_sb_if.slave bus
);
  localparam int              IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0] LP_NREGS = (ADDR_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;

  logic [ADDR_W-1:0] w_ra;
  logic [ADDR_W-1:0] w_rb;
  logic [ADDR_W-1:0] w_rw;
  logic [ADDR_W-1:0] w_issue_rd;
  logic [DATA_W-1:0] w_busw;
  logic              w_regwr;
  logic              w_issue;
  logic              w_wr_legal;

  assign w_ra       = bus.RA;
  assign w_rb       = bus.RB;
  assign w_rw       = bus.RW;
  assign w_issue_rd = bus.IssueRd;
  assign w_busw     = bus.BusW;
  assign w_regwr    = bus.RegWr;
  assign w_issue    = bus.IssueVal;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < LP_NREGS);
  endfunction

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign w_wr_legal = w_regwr && in_range(w_rw) && !is_zero(w_rw);

  // Zero register and out-of-range addresses win over the bypass.
  function automatic logic [DATA_W-1:0] rd_data(input logic [ADDR_W-1:0] a);
    if (!in_range(a) || is_zero(a)) return '0;
    if (w_wr_legal && (w_rw == a))  return w_busw;
    return r_regs[a[IDX_W-1:0]];
  endfunction

  function automatic logic rd_haz(input logic [ADDR_W-1:0] a);
    if (!in_range(a)) return 1'b0;
    return r_busy[a[IDX_W-1:0]] && !(w_regwr && (w_rw == a));
  endfunction

  assign bus.BusA    = Rst ? '0   : rd_data(w_ra);
  assign bus.BusB    = Rst ? '0   : rd_data(w_rb);
  assign bus.HazA    = Rst ? 1'b0 : rd_haz(w_ra);
  assign bus.HazB    = Rst ? 1'b0 : rd_haz(w_rb);
  assign bus.BusyVec = r_busy;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_legal) begin
      r_regs[w_rw[IDX_W-1:0]] <= w_busw;
    end
  end

  // A new issue to the same register beats its writeback: the newer producer owns it.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_issue && (w_issue_rd == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0)))
        w_busy_nxt[i] = 1'b1;
      else if (w_regwr && (w_rw == ADDR_W'(i)))
        w_busy_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

`ifdef REGFILE_DBG_EN
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_dbg
    if ((ZERO_REG != 0) && (g == 0)) begin : g_zero
      assign bus.DbgRegs[g*DATA_W +: DATA_W] = '0;
    end else begin : g_live
      assign bus.DbgRegs[g*DATA_W +: DATA_W] = r_regs[g];
    end
  end
`else
  assign bus.DbgRegs = '0;
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized
// traffic against an array-based reference model.
module tb_reg_file_sb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) b32 ();
  reg_file_sb_if #(.DATA_W(16), .ADDR_W(5), .NUM_REGS(16)) b16 ();

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .ZERO_REG(1)) dut (
    .Clk(clk), .Rst(rst), .bus(b32.slave)
  );
  reg_file_sb #(.DATA_W(16), .ADDR_W(5), .NUM_REGS(16), .ZERO_REG(1)) dut16 (
    .Clk(clk), .Rst(rst), .bus(b16.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];
  logic [15:0] m16_regs [16];

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
    for (int i = 0; i < 16; i++) m16_regs[i] = '0;
  endfunction

  // Clock-edge update of the model: write, then clear-on-writeback, then set-on-issue.
  function automatic void model_commit();
    if (rst) return;
    if (b32.RegWr && b32.RW != 0) m_regs[b32.RW] = b32.BusW;
    if (b32.RegWr) m_busy[b32.RW] = 1'b0;
    if (b32.IssueVal && b32.IssueRd != 0) m_busy[b32.IssueRd] = 1'b1;
    if (b16.RegWr && b16.RW < 16 && b16.RW != 0) m16_regs[b16.RW[3:0]] = b16.BusW;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (rst || a == 0) return 32'h0;
    if (b32.RegWr && b32.RW == a) return b32.BusW;
    return m_regs[a];
  endfunction

  function automatic logic exp_haz(input logic [4:0] a);
    if (rst) return 1'b0;
    return m_busy[a] && !(b32.RegWr && b32.RW == a);
  endfunction

  function automatic logic [31:0] exp_busy();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic idle();
    b32.RA = '0; b32.RB = '0; b32.RW = '0; b32.BusW = '0;
    b32.RegWr = 1'b0; b32.IssueVal = 1'b0; b32.IssueRd = '0;
    b16.RA = '0; b16.RB = '0; b16.RW = '0; b16.BusW = '0;
    b16.RegWr = 1'b0; b16.IssueVal = 1'b0; b16.IssueRd = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    b32.RA = 5'd5;
    #2;
    n_total++; if (b32.BusA !== 32'h0) $display("FAIL rst_init_busa: got %h want 0", b32.BusA); else n_pass++;
    n_total++; if (b32.BusyVec !== 32'h0) $display("FAIL rst_init_busy: got %h want 0", b32.BusyVec); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    b32.RegWr = 1'b1; b32.RW = 5'd5; b32.BusW = 32'hDEADBEEF;
    b32.IssueVal = 1'b1; b32.IssueRd = 5'd6;
    cycle();
    idle();
    b32.RA = 5'd5; b32.RB = 5'd6;
    #2;
    n_total++; if (b32.BusA !== 32'hDEADBEEF) $display("FAIL rst_preload: got %h want deadbeef", b32.BusA); else n_pass++;
    n_total++; if (b32.HazB !== 1'b1) $display("FAIL rst_pre_haz: got %b want 1", b32.HazB); else n_pass++;
    rst = 1'b1;
    model_reset();
    #1;
    n_total++; if (b32.BusA !== 32'h0) $display("FAIL rst_async_busa: got %h want 0", b32.BusA); else n_pass++;
    n_total++; if (b32.BusyVec !== 32'h0) $display("FAIL rst_async_busy: got %h want 0", b32.BusyVec); else n_pass++;
    n_total++; if (b32.HazB !== 1'b0) $display("FAIL rst_async_haz: got %b want 0", b32.HazB); else n_pass++;
    cycle();
    rst = 1'b0;
    #2;
    n_total++; if (b32.BusA !== 32'h0) $display("FAIL rst_after_busa: got %h want 0", b32.BusA); else n_pass++;
  endtask

  task automatic test_write_read();
    idle();
    b32.RegWr = 1'b1; b32.RW = 5'd7; b32.BusW = 32'h12345678;
    cycle();
    idle();
    b32.RA = 5'd7; b32.RB = 5'd7;
    #2;
    n_total++; if (b32.BusA !== 32'h12345678) $display("FAIL wr_busa: got %h want 12345678", b32.BusA); else n_pass++;
    n_total++; if (b32.BusB !== 32'h12345678) $display("FAIL wr_busb: got %h want 12345678", b32.BusB); else n_pass++;
    b32.RegWr = 1'b1; b32.RW = 5'd7; b32.BusW = 32'hA5A5A5A5;
    #1;
    n_total++; if (b32.BusA !== 32'hA5A5A5A5) $display("FAIL bypass_busa: got %h want a5a5a5a5", b32.BusA); else n_pass++;
    cycle();
    idle();
    b32.RA = 5'd7;
    #2;
    n_total++; if (b32.BusA !== 32'hA5A5A5A5) $display("FAIL wr_stored: got %h want a5a5a5a5", b32.BusA); else n_pass++;
  endtask

  task automatic test_zero_reg();
    idle();
    b32.RegWr = 1'b1; b32.RW = 5'd0; b32.BusW = 32'hFFFFFFFF;
    b32.IssueVal = 1'b1; b32.IssueRd = 5'd0; b32.RA = 5'd0;
    #2;
    n_total++; if (b32.BusA !== 32'h0) $display("FAIL zero_bypass: got %h want 0", b32.BusA); else n_pass++;
    cycle();
    idle();
    #2;
    n_total++; if (b32.BusA !== 32'h0) $display("FAIL zero_stored: got %h want 0", b32.BusA); else n_pass++;
    n_total++; if (b32.BusyVec[0] !== 1'b0) $display("FAIL zero_busy: got %b want 0", b32.BusyVec[0]); else n_pass++;
    n_total++; if (b32.HazA !== 1'b0) $display("FAIL zero_haz: got %b want 0", b32.HazA); else n_pass++;
  endtask

  task automatic test_scoreboard();
    idle();
    b32.IssueVal = 1'b1; b32.IssueRd = 5'd9; b32.RA = 5'd9;
    #2;
    n_total++; if (b32.HazA !== 1'b0) $display("FAIL sb_haz_early: got %b want 0", b32.HazA); else n_pass++;
    cycle();
    idle();
    b32.RA = 5'd9;
    #2;
    n_total++; if (b32.HazA !== 1'b1) $display("FAIL sb_haz_set: got %b want 1", b32.HazA); else n_pass++;
    n_total++; if (b32.BusyVec !== 32'h00000200) $display("FAIL sb_busyvec: got %h want 00000200", b32.BusyVec); else n_pass++;
    repeat (6) cycle();
    n_total++; if (b32.BusyVec !== 32'h00000200) $display("FAIL sb_persist: got %h want 00000200", b32.BusyVec); else n_pass++;
    b32.RegWr = 1'b1; b32.RW = 5'd9; b32.BusW = 32'h55;
    #1;
    n_total++; if (b32.HazA !== 1'b0) $display("FAIL sb_wb_haz: got %b want 0", b32.HazA); else n_pass++;
    n_total++; if (b32.BusA !== 32'h55) $display("FAIL sb_wb_busa: got %h want 55", b32.BusA); else n_pass++;
    cycle();
    idle();
    #2;
    n_total++; if (b32.BusyVec !== 32'h0) $display("FAIL sb_cleared: got %h want 0", b32.BusyVec); else n_pass++;
  endtask

  task automatic test_set_clear();
    idle();
    b32.IssueVal = 1'b1; b32.IssueRd = 5'd3;
    cycle();
    idle();
    b32.IssueVal = 1'b1; b32.IssueRd = 5'd3;
    b32.RegWr = 1'b1; b32.RW = 5'd3; b32.BusW = 32'hCAFE0003;
    cycle();
    idle();
    b32.RA = 5'd3;
    #2;
    n_total++; if (b32.BusA !== 32'hCAFE0003) $display("FAIL sc_data: got %h want cafe0003", b32.BusA); else n_pass++;
    n_total++; if (b32.BusyVec[3] !== 1'b1) $display("FAIL sc_busy: got %b want 1", b32.BusyVec[3]); else n_pass++;
    n_total++; if (b32.HazA !== 1'b1) $display("FAIL sc_haz: got %b want 1", b32.HazA); else n_pass++;
    b32.RegWr = 1'b1; b32.RW = 5'd3; b32.BusW = 32'h3;
    cycle();
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      idle();
      b32.RA = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      b32.RB = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      b32.RW = 5'($urandom_range(0, 7));
      b32.IssueRd = 5'($urandom_range(0, 7));
      b32.BusW = $urandom;
      b32.RegWr = 1'($urandom_range(0, 1));
      b32.IssueVal = 1'($urandom_range(0, 1));
      #2;
      n_total++; if (b32.BusA !== exp_rd(b32.RA)) $display("FAIL rnd_busa[%0d]: got %h want %h", n, b32.BusA, exp_rd(b32.RA)); else n_pass++;
      n_total++; if (b32.BusB !== exp_rd(b32.RB)) $display("FAIL rnd_busb[%0d]: got %h want %h", n, b32.BusB, exp_rd(b32.RB)); else n_pass++;
      n_total++; if (b32.HazA !== exp_haz(b32.RA)) $display("FAIL rnd_haza[%0d]: got %b want %b", n, b32.HazA, exp_haz(b32.RA)); else n_pass++;
      n_total++; if (b32.HazB !== exp_haz(b32.RB)) $display("FAIL rnd_hazb[%0d]: got %b want %b", n, b32.HazB, exp_haz(b32.RB)); else n_pass++;
      n_total++; if (b32.BusyVec !== exp_busy()) $display("FAIL rnd_busy[%0d]: got %h want %h", n, b32.BusyVec, exp_busy()); else n_pass++;
      cycle();
    end
    idle();
    #2;
`ifdef REGFILE_DBG_EN
    n_total++; if (b32.DbgRegs[5*32 +: 32] !== m_regs[5]) $display("FAIL rnd_dbg5: got %h want %h", b32.DbgRegs[5*32 +: 32], m_regs[5]); else n_pass++;
    n_total++; if (b32.DbgRegs[31:0] !== 32'h0) $display("FAIL rnd_dbg0: got %h want 0", b32.DbgRegs[31:0]); else n_pass++;
`else
    n_total++; if (b32.DbgRegs !== '0) $display("FAIL rnd_dbg_off: got %h want 0", b32.DbgRegs); else n_pass++;
`endif
  endtask

  task automatic test_params();
    idle();
    b16.RegWr = 1'b1; b16.RW = 5'd4; b16.BusW = 16'h1234;
    cycle();
    idle();
    b16.RegWr = 1'b1; b16.RW = 5'd20; b16.BusW = 16'hBEEF;
    b16.IssueVal = 1'b1; b16.IssueRd = 5'd20;
    b16.RA = 5'd20; b16.RB = 5'd4;
    #2;
    n_total++; if (b16.BusA !== 16'h0) $display("FAIL p16_oor_bypass: got %h want 0", b16.BusA); else n_pass++;
    n_total++; if (b16.BusB !== 16'h1234) $display("FAIL p16_reg4_live: got %h want 1234", b16.BusB); else n_pass++;
    cycle();
    idle();
    b16.RA = 5'd4; b16.RB = 5'd20;
    #2;
    n_total++; if (b16.BusA !== m16_regs[4]) $display("FAIL p16_reg4: got %h want %h", b16.BusA, m16_regs[4]); else n_pass++;
    n_total++; if (b16.BusB !== 16'h0) $display("FAIL p16_oor_read: got %h want 0", b16.BusB); else n_pass++;
    n_total++; if (b16.BusyVec !== 16'h0) $display("FAIL p16_busy: got %h want 0", b16.BusyVec); else n_pass++;
    n_total++; if (b16.HazB !== 1'b0) $display("FAIL p16_haz: got %b want 0", b16.HazB); else n_pass++;
`ifdef REGFILE_DBG_EN
    n_total++; if (b16.DbgRegs[16*4 +: 16] !== 16'h1234) $display("FAIL p16_dbg4: got %h want 1234", b16.DbgRegs[16*4 +: 16]); else n_pass++;
`else
    n_total++; if (b16.DbgRegs !== '0) $display("FAIL p16_dbg_off: got %h want 0", b16.DbgRegs); else n_pass++;
`endif
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    test_reset();
    test_write_read();
    test_zero_reg();
    test_scoreboard();
    test_set_clear();
    test_random();
    test_params();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the CPU's 32x32 RegisterFile: NUM_REGS x DATA_W storage, two combinational read ports, one synchronous write port.
- Adds write-to-read bypass, an optional hard-wired zero register, and a per-register busy scoreboard with hazard flags for the pipelined datapath.
- Sits between decode (RA/RB/issue) and writeback (RW/BusW/RegWr).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width
NUM_REGS, 32, number of registers; must be <= 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy

Ports:
Clk  input  1  clock; all state updates on rising edge
Rst  input  1  asynchronous, active-high reset
RA  input  ADDR_W  read address, port A
RB  input  ADDR_W  read address, port B
BusA  output  DATA_W  read data, port A
BusB  output  DATA_W  read data, port B
RW  input  ADDR_W  write address
BusW  input  DATA_W  write data
RegWr  input  1  write enable
IssueVal  input  1  instruction issued with a destination register this cycle
IssueRd  input  ADDR_W  destination register of the issued instruction
HazA  output  1  operand A not yet available
HazB  output  1  operand B not yet available
BusyVec  output  NUM_REGS  scoreboard busy bits, bit i = register i
DbgRegs  output  DATA_W*NUM_REGS  flattened register contents, reg i at bits [i*DATA_W +: DATA_W]

Behaviour:
- Reset: while Rst=1, all registers = 0 and BusyVec = 0, independent of Clk. Outputs follow combinationally: BusA = BusB = 0, HazA = HazB = 0.
- Write: at posedge, if RegWr and RW < NUM_REGS and not (ZERO_REG and RW==0), then reg[RW] <= BusW.
- Any address >= NUM_REGS:
  - writes are dropped;
  - reads return 0;
  - busy is never set for it;
  - hazard for it is 0.
- Read: BusA/BusB are combinational.
  - Bypass: if RegWr and RW==RA and the write is legal, BusA = BusW in the same cycle. BusB likewise.
  - ZERO_REG=1 and RA==0 gives BusA = 0, regardless of any bypass.
- Scoreboard, evaluated per register i at posedge:
  - set_i = IssueVal and IssueRd==i (excluding reg 0 when ZERO_REG).
  - clr_i = RegWr and RW==i.
  - set_i=1 gives busy <= 1; set wins over a simultaneous clr, because a new producer is issued.
  - Else clr_i=1 gives busy <= 0.
  - Else busy holds.
- Hazards: HazA = busy[RA] and not (RegWr and RW==RA). HazB likewise. The bypass satisfies the read in the writeback cycle.
- Latency: write visible on BusA/BusB in the same cycle via bypass, and from storage in the following cycle. Busy is visible on BusyVec and Haz one cycle after issue.
- Reset mid-operation: pending writes and busy bits are discarded. The first posedge after Rst falls behaves normally.
- Without a matching writeback, a busy bit stays set indefinitely; there is no timeout.

Optional Feature:
- Macro REGFILE_DBG_EN.
  - Defined: DbgRegs drives the live contents of every register, with reg 0 reading 0 when ZERO_REG.
  - Undefined: DbgRegs is tied to 0, and no debug fan-out logic is generated.
- Read, write, scoreboard and hazard behaviour are identical either way.

Test Plan:
- Reset: load reg5 = 0xDEADBEEF, assert Rst asynchronously mid-cycle -> BusA (RA=5) = 0 immediately; BusyVec = 0.
- Write/read: RegWr=1, RW=7, BusW=0x12345678 for 1 cycle; then RA=7, RB=7 -> BusA = BusB = 0x12345678. RA=RW=7 with RegWr=1 and BusW=0xA5A5A5A5 in the same cycle -> BusA = 0xA5A5A5A5 (bypass).
- Zero register: RegWr=1, RW=0, BusW=0xFFFFFFFF; IssueVal=1, IssueRd=0 -> BusA (RA=0) = 0, BusyVec[0] = 0, HazA = 0.
- Scoreboard:
  - IssueVal=1, IssueRd=9, RA=9 -> next cycle HazA = 1, BusyVec = 0x00000200.
  - Writeback RegWr=1, RW=9, BusW=0x55 -> HazA = 0 and BusA = 0x55 in that cycle; next cycle BusyVec = 0.
- Simultaneous set/clear: reg3 busy; IssueVal=1, IssueRd=3 with RegWr=1, RW=3 in the same cycle -> reg3 = BusW, BusyVec[3] stays 1.
- Params: NUM_REGS=16, ADDR_W=5, DATA_W=16; write RW=20 -> no storage change; RA=20 -> BusA = 0. With REGFILE_DBG_EN defined, DbgRegs[16*4 +: 16] matches reg4; undefined -> DbgRegs = 0.
